// File: rtl/lane_arb_pkg.sv
// Shared types and defaults for the lane round-robin arbiter.
package lane_arb_pkg;

    localparam int N_REQ_DEF     = 3;
    localparam int DATA_W_DEF    = 8;
    localparam int BURST_LEN_DEF = 4;

    // Lane index width covers lanes 0..2.
    localparam int LANE_W = 2;

    typedef logic [LANE_W-1:0] lane_idx_t;

    // IDLE: nobody owns the shared channel. OWN: one lane owns it.
    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    // Last owner after reset is lane c, so lane a is first in line.
    localparam lane_idx_t RESET_LAST_OWNER = lane_idx_t'(2);

endpackage

// File: rtl/lane_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: first requesting lane after last_owner,
// scanning cyclically 0,1,2,0.
module rr_pick
    import lane_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) (
    input  logic [N_REQ-1:0]  i_req,
    input  logic [LANE_W-1:0] i_last_owner,
    output logic [LANE_W-1:0] o_pick,
    output logic              o_pick_valid
);

    // Scan from the farthest candidate to the nearest so the nearest
    // requesting lane after last_owner is the one left standing.
    always_comb begin
        int        idx;
        lane_idx_t sel;
        idx          = 0;
        sel          = '0;
        o_pick       = i_last_owner;
        o_pick_valid = 1'b0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(i_last_owner) + k) % N_REQ;
            sel = lane_idx_t'(idx);
            if (i_req[sel]) begin
                o_pick       = sel;
                o_pick_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lane_rr_arbiter.sv
// Three-lane round-robin arbiter onto one valid/ready channel. A granted
// lane owns the channel for up to BURST_LEN beats or until it drops its
// request; every release is followed by one idle cycle before the next grant.
module lane_rr_arbiter
    import lane_arb_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BURST_LEN = BURST_LEN_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N_REQ-1:0]  i_req,
    input  logic [DATA_W-1:0] i_data_a,
    input  logic [DATA_W-1:0] i_data_b,
    input  logic [DATA_W-1:0] i_data_c,
    output logic [N_REQ-1:0]  o_gnt,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        o_src,
    output logic              o_busy
);

    // A one-beat burst would need a zero-width counter; keep at least one bit.
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

    arb_state_t        state;
    arb_state_t        state_nxt;
    lane_idx_t         owner;
    lane_idx_t         owner_nxt;
    lane_idx_t         last_owner;
    lane_idx_t         last_owner_nxt;
    logic [BEAT_W-1:0] beat_cnt;
    logic [BEAT_W-1:0] beat_cnt_nxt;

    lane_idx_t         pick_idx;
    logic              pick_valid;
    logic              owner_req;
    logic [DATA_W-1:0] owner_data;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .i_req        (i_req),
        .i_last_owner (last_owner),
        .o_pick       (pick_idx),
        .o_pick_valid (pick_valid)
    );

    assign owner_req = i_req[owner];

    // Route the owning lane's payload; other lanes never reach the output.
    always_comb begin
        owner_data = i_data_c;
        case (owner)
            lane_idx_t'(0): owner_data = i_data_a;
            lane_idx_t'(1): owner_data = i_data_b;
            default:        owner_data = i_data_c;
        endcase
    end

    // Next-state logic and channel outputs, all derived from state and owner.
    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        beat_cnt_nxt   = beat_cnt;
        o_gnt          = '0;
        o_valid        = 1'b0;
        o_data         = '0;
        o_busy         = 1'b0;
        o_src          = last_owner;

        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_nxt    = OWN;
                    owner_nxt    = pick_idx;
                    beat_cnt_nxt = '0;
                end
            end

            OWN: begin
                o_busy       = 1'b1;
                o_src        = owner;
                o_valid      = owner_req;
                o_data       = owner_data;
                o_gnt[owner] = i_ready;

                // Release on a dropped request or on the final beat of a burst.
                if (!owner_req || (i_ready && (beat_cnt == BEAT_LAST))) begin
                    state_nxt      = IDLE;
                    last_owner_nxt = owner;
                    beat_cnt_nxt   = '0;
                end else if (i_ready) begin
                    beat_cnt_nxt = beat_cnt + BEAT_W'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Control state register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            owner      <= RESET_LAST_OWNER;
            last_owner <= RESET_LAST_OWNER;
            beat_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_owner_nxt;
            beat_cnt   <= beat_cnt_nxt;
        end
    end

    // Structural invariants: at most one grant, counter stays in range.
    gnt_onehot0 : assert property (@(posedge i_clk) disable iff (i_rst) $onehot0(o_gnt));
    beat_in_range : assert property (@(posedge i_clk) disable iff (i_rst) beat_cnt <= BEAT_LAST);

endmodule

// File: doc/lane_rr_arbiter.md
LANE_RR_ARBITER -- requirements
Module: lane_rr_arbiter

Interface
REQ-001 Parameter N_REQ, default 3: number of requesters (lanes a, b, c).
REQ-002 Parameter DATA_W, default 8: lane and output data width.
REQ-003 Parameter BURST_LEN, default 4: maximum beats per grant before forced release.
REQ-004 i_clk  in  1  sole clock; all state changes on rising edge.
REQ-005 i_rst  in  1  synchronous, active-high reset.
REQ-006 i_req  in  N_REQ  per-lane request/valid; bit 0 = lane a.
REQ-007 i_data_a, i_data_b, i_data_c  in  DATA_W each  lane payloads.
REQ-008 o_gnt  out  N_REQ  per-lane ready; one-hot or zero.
REQ-009 o_valid  out  1  shared channel valid.
REQ-010 i_ready  in  1  shared channel ready from sink.
REQ-011 o_data  out  DATA_W  shared channel payload.
REQ-012 o_src  out  2  index of current owner lane (0..2).
REQ-013 o_busy  out  1  high while a lane owns the channel.

Function
REQ-014 The FSM SHALL have two states: IDLE (no owner) and OWN (one lane owns the channel).
REQ-015 In IDLE with any i_req bit set, the owner SHALL be the first requesting lane after last_owner in cyclic order 0,1,2,0; next state OWN, beat_cnt cleared.
REQ-016 In IDLE with i_req == 0, the FSM SHALL remain in IDLE; last_owner unchanged.
REQ-017 Arbitration latency SHALL be one cycle: request sampled in IDLE, o_valid possible in the following cycle.
REQ-018 In OWN: o_valid = i_req[owner]; o_data = owner lane data; o_gnt[owner] = i_ready; all other o_gnt bits 0 (combinational from state/owner).
REQ-019 A beat SHALL transfer when o_valid && i_ready; beat_cnt increments by 1 per beat.
REQ-020 OWN SHALL release to IDLE, setting last_owner = owner, when a beat transfers with beat_cnt == BURST_LEN-1, or when i_req[owner] is low.
REQ-021 After release, one IDLE bubble cycle SHALL occur before the next grant, even if requests are pending.
REQ-022 Payload or request changes on non-owner lanes SHALL have no effect on outputs during OWN.
REQ-023 With i_ready low in OWN, the state SHALL hold and o_data SHALL track owner lane data; no beat is counted.
REQ-024 In IDLE: o_valid = 0, o_gnt = 0, o_data = 0, o_busy = 0; o_src holds last_owner.
REQ-025 beat_cnt SHALL be clog2(BURST_LEN) bits wide and never exceed BURST_LEN-1.

Reset
REQ-026 While i_rst is high at a clock edge: state = IDLE, beat_cnt = 0, last_owner = 2 (lane a has first priority).
REQ-027 Reset values: o_gnt = 0, o_valid = 0, o_data = 0, o_busy = 0, o_src = 2.
REQ-028 Reset during OWN SHALL abort the burst with no further beat transferred; the abort takes effect in the cycle after the edge.

Structure
REQ-029 A shared package lane_arb_pkg SHALL hold the FSM state enum (IDLE, OWN), N_REQ/DATA_W/BURST_LEN defaults, and the lane index type.
REQ-030 One sub-module, rr_pick, SHALL implement the combinational round-robin selection (inputs i_req and last_owner; outputs pick index and pick_valid).

Verification
REQ-031 Reset, then i_req=3'b001, i_ready=1, i_data_a=8'hA5 -> o_valid=1 from cycle 2, o_src=0, o_gnt=3'b001, 4 beats of 8'hA5, then 1 IDLE cycle.
REQ-032 i_req=3'b111 held, i_ready=1 -> grant order a,b,c,a; each burst 4 beats; one idle cycle between bursts; o_src sequence 0,1,2,0.
REQ-033 Owner b, i_ready=0 for 3 cycles -> o_valid=1, o_gnt=0, beat_cnt frozen; i_ready back to 1 -> remaining beats complete.
REQ-034 Owner a drops i_req[0] after 2 beats while c requests -> release, last_owner=0, c granted next (o_src=2).
REQ-035 i_rst asserted mid-burst (owner c, beat 2) -> next cycle o_valid=0, o_busy=0, o_src=2; with i_req=3'b101 afterwards -> lane a granted first.
